// File: rtl/sctag_evicttag_pipe_dp.sv
// L2 tag-side address datapath: arbitration source registers, lookup address
// pipeline with C1 freeze, writeback address merge and a DRAM request queue.
module sctag_evicttag_pipe_dp #(
   parameter int ADDR_W     = 40,
   parameter int NSRC       = 2,
   parameter int PIPE_DEPTH = 4,
   parameter int TAG_LSB    = 18,
   parameter int DQ_DEPTH   = 4
) (
   input  logic                           rclk,
   input  logic                           rst,
   input  logic [NSRC*ADDR_W-1:0]         src_addr,
   input  logic [NSRC-1:0]                src_ld,
   input  logic [NSRC-1:0]                src_sel_px1,
   output logic [ADDR_W-1:0]              evicttag_addr_px2,
   input  logic [ADDR_W-1:0]              arbdp_cam_addr_px2,
   input  logic                           sehold,
   output logic [ADDR_W-9:0]              lkup_addr_c1,
   output logic [ADDR_W-1:0]              mb_write_addr,
   output logic [TAG_LSB-9:0]             vuad_idx_c3,
   input  logic [ADDR_W-TAG_LSB-1:0]      tagdp_evict_tag_cn,
   input  logic                           arbctl_evict_cn,
   output logic [ADDR_W-1:0]              wb_write_addr,
   input  logic                           dram_rd_req,
   output logic                           dram_rd_accept,
   input  logic [ADDR_W-7:0]              wb_rd_data,
   input  logic [ADDR_W-7:0]              rdma_rd_data,
   input  logic                           wbctl_wr_addr_sel,
   input  logic                           dram_wr_req,
   output logic                           dram_wr_accept,
   output logic                           sctag_dram_vld,
   output logic                           sctag_dram_wr,
   output logic [ADDR_W-6:0]              sctag_dram_addr,
   input  logic                           dram_sctag_rdy,
   output logic [ADDR_W-7:0]              evict_addr,
   output logic [$clog2(DQ_DEPTH):0]      dq_cnt
);

   localparam int PTR_W = $clog2(DQ_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = ADDR_W - 4;   // {is_wr, addr[ADDR_W-1:5]}

   logic [ADDR_W-1:0] src_q  [NSRC];
   logic [NSRC-1:0]   sel_q;
   logic [ADDR_W-1:0] pipe_q [PIPE_DEPTH];   // index 0 is C1
   logic [ADDR_W-1:0] c1_d;
   logic [ADDR_W-1:0] cn;

   logic [ENT_W-1:0]  dq_mem_q [DQ_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-7:0] evict_q;
   logic [ADDR_W-7:0] wr_addr;
   logic [ENT_W-1:0]  push_ent;
   logic              full, push, pop;

   // Arbitration: lowest-index set select bit wins; no select yields zero.
   always_comb begin
      evicttag_addr_px2 = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (sel_q[i]) evicttag_addr_px2 = src_q[i];
      end
   end

   // C1 freezes under sehold; downstream stages always advance.
   always_comb begin
      c1_d = sehold ? pipe_q[0] : arbdp_cam_addr_px2;
   end

   assign lkup_addr_c1  = pipe_q[0][ADDR_W-1:8];
   assign mb_write_addr = pipe_q[1];
   assign vuad_idx_c3   = pipe_q[2][TAG_LSB-1:8];
   assign cn            = pipe_q[PIPE_DEPTH-1];

   // Eviction replaces the tag and clears the line offset of the last-stage address.
   always_comb begin
      wb_write_addr = cn;
      if (arbctl_evict_cn) wb_write_addr = {tagdp_evict_tag_cn, cn[TAG_LSB-1:6], 6'b0};
   end

   // Queue control: reads win over writes; a full queue rejects even with a pop pending.
   always_comb begin
      wr_addr        = wbctl_wr_addr_sel ? wb_rd_data : rdma_rd_data;
      full           = (cnt_q == CNT_W'(DQ_DEPTH));
      dram_rd_accept = dram_rd_req & ~full & ~rst;
      dram_wr_accept = dram_wr_req & ~full & ~dram_rd_req & ~rst;
      push           = dram_rd_accept | dram_wr_accept;
      pop            = sctag_dram_vld & dram_sctag_rdy & ~rst;
      push_ent       = dram_rd_accept ? {1'b0, src_addr[ADDR_W-1:5]} : {1'b1, wr_addr, 1'b0};
      wr_ptr_d       = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d       = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      cnt_d          = cnt_q;
      if (push && !pop) cnt_d = cnt_q + 1'b1;
      else if (!push && pop) cnt_d = cnt_q - 1'b1;
   end

   assign sctag_dram_vld  = (cnt_q != '0);
   assign sctag_dram_wr   = dq_mem_q[rd_ptr_q][ENT_W-1];
   assign sctag_dram_addr = dq_mem_q[rd_ptr_q][ENT_W-2:0];
   assign evict_addr      = evict_q;
   assign dq_cnt          = cnt_q;

   // All state: source regs, select, pipeline, queue storage and pointers.
   always_ff @(posedge rclk) begin
      if (rst) begin
         for (int i = 0; i < NSRC; i++) src_q[i] <= '0;
         for (int k = 0; k < PIPE_DEPTH; k++) pipe_q[k] <= '0;
         for (int e = 0; e < DQ_DEPTH; e++) dq_mem_q[e] <= '0;
         sel_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         evict_q  <= '0;
      end else begin
         for (int i = 0; i < NSRC; i++) begin
            if (src_ld[i]) src_q[i] <= src_addr[i*ADDR_W +: ADDR_W];
         end
         sel_q     <= src_sel_px1;
         pipe_q[0] <= c1_d;
         for (int k = 1; k < PIPE_DEPTH; k++) pipe_q[k] <= pipe_q[k-1];
         if (push) dq_mem_q[wr_ptr_q] <= push_ent;
         if (dram_wr_accept) evict_q <= wr_addr;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_sctag_evicttag_pipe_dp.sv
// Bench for sctag_evicttag_pipe_dp: directed scenarios with literal expectations
// followed by randomized traffic, all compared every cycle against a queue-based model.
module tb_sctag_evicttag_pipe_dp;

   localparam int ADDR_W     = 40;
   localparam int NSRC       = 2;
   localparam int PIPE_DEPTH = 4;
   localparam int TAG_LSB    = 18;
   localparam int DQ_DEPTH   = 4;

   logic                 rclk = 1'b0;
   logic                 rst;
   logic [NSRC*ADDR_W-1:0] src_addr;
   logic [NSRC-1:0]      src_ld, src_sel_px1;
   logic [39:0]          evicttag_addr_px2, arbdp_cam_addr_px2;
   logic                 sehold;
   logic [31:0]          lkup_addr_c1;
   logic [39:0]          mb_write_addr;
   logic [9:0]           vuad_idx_c3;
   logic [21:0]          tagdp_evict_tag_cn;
   logic                 arbctl_evict_cn;
   logic [39:0]          wb_write_addr;
   logic                 dram_rd_req, dram_rd_accept;
   logic [33:0]          wb_rd_data, rdma_rd_data;
   logic                 wbctl_wr_addr_sel;
   logic                 dram_wr_req, dram_wr_accept;
   logic                 sctag_dram_vld, sctag_dram_wr;
   logic [34:0]          sctag_dram_addr;
   logic                 dram_sctag_rdy;
   logic [33:0]          evict_addr;
   logic [2:0]           dq_cnt;

   sctag_evicttag_pipe_dp #(
      .ADDR_W(ADDR_W), .NSRC(NSRC), .PIPE_DEPTH(PIPE_DEPTH),
      .TAG_LSB(TAG_LSB), .DQ_DEPTH(DQ_DEPTH)
   ) dut (
      .rclk(rclk), .rst(rst),
      .src_addr(src_addr), .src_ld(src_ld), .src_sel_px1(src_sel_px1),
      .evicttag_addr_px2(evicttag_addr_px2),
      .arbdp_cam_addr_px2(arbdp_cam_addr_px2), .sehold(sehold),
      .lkup_addr_c1(lkup_addr_c1), .mb_write_addr(mb_write_addr),
      .vuad_idx_c3(vuad_idx_c3),
      .tagdp_evict_tag_cn(tagdp_evict_tag_cn), .arbctl_evict_cn(arbctl_evict_cn),
      .wb_write_addr(wb_write_addr),
      .dram_rd_req(dram_rd_req), .dram_rd_accept(dram_rd_accept),
      .wb_rd_data(wb_rd_data), .rdma_rd_data(rdma_rd_data),
      .wbctl_wr_addr_sel(wbctl_wr_addr_sel),
      .dram_wr_req(dram_wr_req), .dram_wr_accept(dram_wr_accept),
      .sctag_dram_vld(sctag_dram_vld), .sctag_dram_wr(sctag_dram_wr),
      .sctag_dram_addr(sctag_dram_addr), .dram_sctag_rdy(dram_sctag_rdy),
      .evict_addr(evict_addr), .dq_cnt(dq_cnt)
   );

   always #5 rclk = ~rclk;

   // Reference model state
   logic [39:0] m_src [NSRC];
   logic [1:0]  m_sel;
   logic [39:0] m_c1_hist [$];   // [k] = C1 value k cycles ago, i.e. stage C(k+1)
   logic [35:0] m_q [$];         // queued {is_wr, addr[39:5]}, head first
   logic [33:0] m_evict;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NSRC; i++) m_src[i] = '0;
      m_sel = '0;
      m_c1_hist.delete();
      for (int k = 0; k < PIPE_DEPTH; k++) m_c1_hist.push_back(40'h0);
      m_q.delete();
      m_evict = '0;
   endtask

   // Compare every output against the model, then advance the model by one clock.
   task automatic compare_and_update();
      logic [39:0] exp_evt, cn, exp_wb;
      logic [33:0] wr;
      bit          full, e_rd, e_wr;
      exp_evt = '0;
      for (int i = NSRC - 1; i >= 0; i--) if (m_sel[i]) exp_evt = m_src[i];
      cn     = m_c1_hist[PIPE_DEPTH-1];
      exp_wb = arbctl_evict_cn ? ({tagdp_evict_tag_cn, 18'b0} | (cn & 40'h3FFC0)) : cn;
      full   = (m_q.size() == DQ_DEPTH);
      e_rd   = dram_rd_req && !full && !rst;
      e_wr   = dram_wr_req && !dram_rd_req && !full && !rst;
      wr     = wbctl_wr_addr_sel ? wb_rd_data : rdma_rd_data;

      chk("evicttag", 64'(evicttag_addr_px2), 64'(exp_evt));
      chk("lkup_c1", 64'(lkup_addr_c1), 64'(m_c1_hist[0][39:8]));
      chk("mb_addr", 64'(mb_write_addr), 64'(m_c1_hist[1]));
      chk("vuad_c3", 64'(vuad_idx_c3), 64'(m_c1_hist[2][17:8]));
      chk("wb_addr", 64'(wb_write_addr), 64'(exp_wb));
      chk("rd_accept", 64'(dram_rd_accept), 64'(e_rd));
      chk("wr_accept", 64'(dram_wr_accept), 64'(e_wr));
      chk("dram_vld", 64'(sctag_dram_vld), 64'(m_q.size() != 0));
      chk("dq_cnt", 64'(dq_cnt), 64'(m_q.size()));
      chk("evict_addr", 64'(evict_addr), 64'(m_evict));
      if (m_q.size() != 0) begin
         chk("head_wr", 64'(sctag_dram_wr), 64'(m_q[0][35]));
         chk("head_addr", 64'(sctag_dram_addr), 64'(m_q[0][34:0]));
      end

      if (rst) begin
         model_reset();
      end else begin
         for (int i = 0; i < NSRC; i++) if (src_ld[i]) m_src[i] = src_addr[i*ADDR_W +: ADDR_W];
         m_sel = src_sel_px1;
         m_c1_hist.push_front(sehold ? m_c1_hist[0] : arbdp_cam_addr_px2);
         void'(m_c1_hist.pop_back());
         if (m_q.size() != 0 && dram_sctag_rdy) void'(m_q.pop_front());
         if (e_rd) m_q.push_back({1'b0, src_addr[39:5]});
         else if (e_wr) begin
            m_q.push_back({1'b1, wr, 1'b0});
            m_evict = wr;
         end
      end
   endtask

   // Inputs are set at posedge+1; outputs are compared at posedge+3.
   task automatic step();
      #2;
      compare_and_update();
      @(posedge rclk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL timeout: simulation exceeded its time budget");
      $fatal(1, "timeout");
   end

   initial begin
      logic [33:0] last_wr;
      last_wr = '0;
      rst = 1'b1; src_addr = '0; src_ld = '0; src_sel_px1 = '0;
      arbdp_cam_addr_px2 = '0; sehold = 1'b0; tagdp_evict_tag_cn = '0;
      arbctl_evict_cn = 1'b0; dram_rd_req = 1'b0; wb_rd_data = '0; rdma_rd_data = '0;
      wbctl_wr_addr_sel = 1'b0; dram_wr_req = 1'b0; dram_sctag_rdy = 1'b0;
      @(posedge rclk);
      #1;
      model_reset();
      step();
      rst = 1'b0;

      // Reset state
      chk("rst_cnt", 64'(dq_cnt), 64'd0);
      chk("rst_vld", 64'(sctag_dram_vld), 64'd0);
      chk("rst_evt", 64'(evicttag_addr_px2), 64'd0);
      chk("rst_head", 64'(sctag_dram_addr), 64'd0);

      // Arbitration select
      src_ld = 2'b11;
      src_addr = {40'h12_3456_7880, 40'hAB_CDEF_0040};
      src_sel_px1 = 2'b01;
      step();
      src_ld = 2'b00;
      chk("arb_mb", 64'(evicttag_addr_px2), 64'hAB_CDEF_0040);
      src_sel_px1 = 2'b10; step();
      chk("arb_fb", 64'(evicttag_addr_px2), 64'h12_3456_7880);
      src_sel_px1 = 2'b11; step();
      chk("arb_multi", 64'(evicttag_addr_px2), 64'hAB_CDEF_0040);
      src_sel_px1 = 2'b00; step();
      chk("arb_none", 64'(evicttag_addr_px2), 64'd0);

      // Pipeline with sehold
      arbdp_cam_addr_px2 = 40'h100; step();
      chk("c1_first", 64'(lkup_addr_c1), 64'h1);
      arbdp_cam_addr_px2 = 40'h200; sehold = 1'b1; step();
      chk("c1_hold", 64'(lkup_addr_c1), 64'h1);
      chk("c2_first", 64'(mb_write_addr), 64'h100);
      arbdp_cam_addr_px2 = 40'h300; sehold = 1'b0; step();
      chk("c1_next", 64'(lkup_addr_c1), 64'h3);
      chk("c2_hold", 64'(mb_write_addr), 64'h100);
      chk("c3_idx", 64'(vuad_idx_c3), 64'h001);
      step();
      chk("c2_next", 64'(mb_write_addr), 64'h300);

      // Writeback merge
      arbdp_cam_addr_px2 = 40'h55_5555_5FC0;
      repeat (PIPE_DEPTH) step();
      tagdp_evict_tag_cn = 22'h3FFFFF; arbctl_evict_cn = 1'b1;
      #1 chk("wb_merge", 64'(wb_write_addr), 64'hFF_FFFD_5FC0);
      arbctl_evict_cn = 1'b0;
      #1 chk("wb_pass", 64'(wb_write_addr), 64'h55_5555_5FC0);

      // Priority and fill with DRAM stalled
      dram_sctag_rdy = 1'b0; dram_rd_req = 1'b1; dram_wr_req = 1'b1;
      wbctl_wr_addr_sel = 1'b1; wb_rd_data = 34'($urandom());
      for (int i = 0; i < 5; i++) begin
         src_addr[39:0] = 40'({$urandom(), $urandom()});
         #1;
         chk("fill_rd_acc", 64'(dram_rd_accept), 64'(i < 4));
         chk("fill_wr_acc", 64'(dram_wr_accept), 64'd0);
         step();
      end
      chk("fill_cnt", 64'(dq_cnt), 64'd4);

      // Drain with one write per cycle across pointer wrap
      dram_rd_req = 1'b0; dram_sctag_rdy = 1'b1;
      for (int i = 0; i < 10; i++) begin
         wbctl_wr_addr_sel = 1'($urandom());
         wb_rd_data   = 34'({$urandom(), $urandom()});
         rdma_rd_data = 34'({$urandom(), $urandom()});
         #1;
         chk("drain_wr_acc", 64'(dram_wr_accept), 64'(i > 0));
         if (i > 0) last_wr = wbctl_wr_addr_sel ? wb_rd_data : rdma_rd_data;
         step();
         chk("drain_cnt", 64'(dq_cnt), 64'd3);
      end
      chk("drain_evict", 64'(evict_addr), 64'(last_wr));
      chk("drain_head_wr", 64'(sctag_dram_wr), 64'd1);
      chk("drain_bit5", 64'(sctag_dram_addr[0]), 64'd0);

      // Reset mid-operation
      arbdp_cam_addr_px2 = 40'(({$urandom(), $urandom()}));
      step();
      rst = 1'b1; step();
      rst = 1'b0;
      chk("mid_rst_vld", 64'(sctag_dram_vld), 64'd0);
      chk("mid_rst_cnt", 64'(dq_cnt), 64'd0);
      chk("mid_rst_wb", 64'(wb_write_addr), 64'd0);
      dram_rd_req = 1'b1; dram_wr_req = 1'b0; dram_sctag_rdy = 1'b0;
      #1 chk("post_rst_acc", 64'(dram_rd_accept), 64'd1);
      step();
      chk("post_rst_cnt", 64'(dq_cnt), 64'd1);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst                = ($urandom_range(0, 99) == 0);
         src_ld             = 2'($urandom());
         src_addr           = 80'({$urandom(), $urandom(), $urandom()});
         src_sel_px1        = 2'($urandom());
         arbdp_cam_addr_px2 = 40'({$urandom(), $urandom()});
         sehold             = ($urandom_range(0, 3) == 0);
         tagdp_evict_tag_cn = 22'($urandom());
         arbctl_evict_cn    = 1'($urandom());
         dram_rd_req        = ($urandom_range(0, 2) == 0);
         dram_wr_req        = 1'($urandom());
         dram_sctag_rdy     = ($urandom_range(0, 2) != 0) ? 1'($urandom()) : 1'b0;
         wbctl_wr_addr_sel  = 1'($urandom());
         wb_rd_data         = 34'({$urandom(), $urandom()});
         rdma_rd_data       = 34'({$urandom(), $urandom()});
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
